// File: rtl/dm_store_buffer.sv
// dm_store_buffer: store write buffer between the MEM stage and the data memory.
// The buffer accepts aligned sw/sh/sb stores and generates a byte-write-enable
// pattern for each one. It queues up to DEPTH stores in FIFO order and drains
// one per cycle into the data memory write port. It also flags loads that hit
// a word with a pending store.
// Optional feature: define STBUF_BYPASS_EN to let a store reach the data memory
// port in its own cycle when the queue is empty and the port is free.
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 13
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   st_req,
    input  logic [1:0]             st_type,
    input  logic [AW-1:0]          st_addr,
    input  logic [31:0]            st_data,
    output logic                   st_ready,
    input  logic                   ld_req,
    input  logic [AW-1:0]          ld_addr,
    output logic                   ld_hazard,
    output logic                   misalign,
    input  logic                   dm_hold,
    output logic                   dm_we,
    output logic [3:0]             dm_bwe,
    output logic [AW-1:0]          dm_addr,
    output logic [31:0]            dm_din,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Queue storage. The entries are plain registers because every entry is
    // compared against the load address in parallel.
    logic [AW-1:0]    addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [3:0]       bwe_mem  [DEPTH];
    logic [DEPTH-1:0] valid_reg;

    logic [PW-1:0] head_reg;
    logic [PW-1:0] tail_reg;
    logic [CW-1:0] count_reg;
    logic          misalign_reg;

    logic       st_aligned;
    logic [3:0] st_bwe;
    logic       full;
    logic       fifo_drain;
    logic       bypass;
    logic       enq;
    logic       bypass_hit;
    logic [DEPTH-1:0] entry_hit;

    // Only word-granular addresses matter for hazards; the byte offset of the
    // load is intentionally ignored.
    logic unused_ld_bits;
    assign unused_ld_bits = ^ld_addr[1:0];

    // Decode the store type into an alignment verdict and a byte-lane mask.
    always_comb begin
        st_aligned = 1'b0;
        st_bwe     = 4'b0000;
        case (st_type)
            2'b00: begin
                st_aligned = (st_addr[1:0] == 2'b00);
                st_bwe     = 4'b1111;
            end
            2'b01: begin
                st_aligned = ~st_addr[0];
                st_bwe     = st_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                st_aligned = 1'b1;
                st_bwe     = 4'b0001 << st_addr[1:0];
            end
            default: begin
                st_aligned = 1'b0;
                st_bwe     = 4'b0000;
            end
        endcase
    end

    // Acceptance is based on the registered count only. A full buffer refuses
    // a store even if the head drains in the same cycle.
    assign full       = (count_reg == CW'(DEPTH));
    assign fifo_drain = reset && (count_reg != '0) && !dm_hold;

`ifdef STBUF_BYPASS_EN
    // An empty queue with a free port sends the store straight through.
    assign bypass = reset && st_req && st_aligned && (count_reg == '0) && !dm_hold;
`else
    assign bypass = 1'b0;
`endif

    assign enq = reset && st_req && st_aligned && !full && !bypass;

    // Drive the memory port from the head entry, or from the bypassing store.
    // The port is forced idle while reset is asserted.
    always_comb begin
        dm_we   = fifo_drain || bypass;
        dm_addr = addr_mem[head_reg];
        dm_din  = data_mem[head_reg];
        dm_bwe  = 4'b0000;
        if (bypass) begin
            dm_addr = st_addr;
            dm_din  = st_data;
            dm_bwe  = st_bwe;
        end else if (fifo_drain) begin
            dm_bwe  = bwe_mem[head_reg];
        end
    end

    // Compare each valid entry's word address against the load word.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign entry_hit[gi] = valid_reg[gi] &&
                                   (addr_mem[gi][AW-1:2] == ld_addr[AW-1:2]);
        end
    endgenerate

    assign bypass_hit = bypass && (st_addr[AW-1:2] == ld_addr[AW-1:2]);
    assign ld_hazard  = reset && ld_req && ((|entry_hit) || bypass_hit);
    assign st_ready   = !reset || !full;
    assign misalign   = misalign_reg;
    assign count      = count_reg;

    // Pointer, occupancy and misalign-pulse registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= st_req && !st_aligned;
            if (enq) begin
                tail_reg <= tail_reg + PW'(1);
            end
            if (fifo_drain) begin
                head_reg <= head_reg + PW'(1);
            end
            case ({enq, fifo_drain})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Per-entry valid bits. An entry is set on enqueue and cleared when it drains.
    // Head and tail can only coincide when the queue is empty or full. In those
    // states, the set and clear conditions cannot both be true.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            // Track whether slot gi holds a pending store.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    valid_reg[gi] <= 1'b0;
                end else if (enq && (tail_reg == PW'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end else if (fifo_drain && (head_reg == PW'(gi))) begin
                    valid_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // Write the payload of an accepted store into the tail slot.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[tail_reg] <= st_addr;
            data_mem[tail_reg] <= st_data;
            bwe_mem[tail_reg]  <= st_bwe;
        end
    end

endmodule
